// File: rtl/rot_step_sequencer.sv
// -----------------------------------------------------------------------------
// rot_step_sequencer
//
// Drives the stepper rotation stage and the angle counter / 7-segment path.
// When start is accepted, the block emits exactly target_steps pulses on
// rot_clk. Each pulse is high for hp_eff cycles and low for hp_eff cycles,
// where hp_eff = max(half_period, HP_MIN). rot_en frames the whole burst.
// The final low phase is a TAIL phase that keeps rot_en asserted while the
// downstream falling-edge detector fires. An abort finishes the current step
// and then ends the burst early.
//
// Ports
//   fpga_clk      in   system clock, all logic on the rising edge
//   sys_init_ctrl in   synchronous active-high reset, priority over all inputs
//   start         in   single-cycle request, sampled only in IDLE
//   abort         in   level or pulse, requests an early stop
//   target_steps  in   number of rot_clk pulses, latched on accept
//   half_period   in   rot_clk high/low time in cycles, latched on accept
//   rot_clk       out  step clock to the motor and the angle counter
//   rot_en        out  high for the whole burst, including the tail
//   busy          out  high from accept until DONE
//   done          out  single-cycle pulse at end of burst
//   aborted       out  set with done if the burst ended early, held until
//                      the next accepted start
//   steps_done    out  rot_clk falling edges issued in the current/last burst
// -----------------------------------------------------------------------------
module rot_step_sequencer #(
  parameter int CNT_W  = 14,
  parameter int HP_W   = 16,
  parameter int HP_MIN = 4
) (
  input  logic             fpga_clk,
  input  logic             sys_init_ctrl,
  input  logic             start,
  input  logic             abort,
  input  logic [CNT_W-1:0] target_steps,
  input  logic [HP_W-1:0]  half_period,
  output logic             rot_clk,
  output logic             rot_en,
  output logic             busy,
  output logic             done,
  output logic             aborted,
  output logic [CNT_W-1:0] steps_done
);

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_HIGH = 3'd1,
    ST_LOW  = 3'd2,
    ST_TAIL = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  localparam logic [HP_W-1:0]  HP_MIN_L = HP_W'(HP_MIN);
  localparam logic [HP_W-1:0]  HP_ONE   = HP_W'(1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  // ---------------------------------------------------------------------------
  // State and datapath registers
  // ---------------------------------------------------------------------------
  state_e           state_q,      state_d;
  logic [HP_W-1:0]  phase_q,      phase_d;      // counts hp_eff-1 down to 0
  logic [HP_W-1:0]  hp_q,         hp_d;         // latched hp_eff
  logic [CNT_W-1:0] target_q,     target_d;
  logic [CNT_W-1:0] steps_q,      steps_d;
  logic             abort_pend_q, abort_pend_d;
  logic             aborted_q,    aborted_d;

  // Outputs are registered so rot_clk and rot_en are clean flop outputs,
  // never a decode of a multi-bit state vector that could glitch.
  logic rot_clk_q, rot_clk_d;
  logic rot_en_q,  rot_en_d;
  logic busy_q,    busy_d;
  logic done_q,    done_d;

  // ---------------------------------------------------------------------------
  // Helper terms
  // ---------------------------------------------------------------------------
  logic [HP_W-1:0]  hp_in_eff;
  logic             in_burst;
  logic             abort_seen;
  logic             phase_expired;
  logic [CNT_W-1:0] steps_inc;

  // The half-period is clamped so the downstream edge detector always sees
  // at least HP_MIN cycles per level.
  assign hp_in_eff = (half_period < HP_MIN_L) ? HP_MIN_L : half_period;

  assign in_burst = (state_q == ST_HIGH) || (state_q == ST_LOW) ||
                    (state_q == ST_TAIL);

  // An abort in the current cycle counts immediately. Without this, an abort
  // arriving on the last cycle of a phase would be one phase late.
  assign abort_seen = abort_pend_q || (in_burst && abort);

  assign phase_expired = (phase_q == '0);

  // Saturating step counter. It cannot wrap, even if target_steps is all-ones.
  assign steps_inc = (&steps_q) ? steps_q : (steps_q + CNT_ONE);

  // ---------------------------------------------------------------------------
  // Next-state and output logic
  // ---------------------------------------------------------------------------
  always_comb begin
    // NOTE: every variable gets a default before the case statement. Any path
    // that leaves one unassigned would infer a latch.
    state_d      = state_q;
    phase_d      = phase_q;
    hp_d         = hp_q;
    target_d     = target_q;
    steps_d      = steps_q;
    abort_pend_d = abort_pend_q;
    aborted_d    = aborted_q;

    unique case (state_q)
      ST_IDLE: begin
        // A start qualified by abort is dropped entirely.
        if (start && !abort) begin
          target_d     = target_steps;
          hp_d         = hp_in_eff;
          phase_d      = hp_in_eff - HP_ONE;
          steps_d      = '0;
          aborted_d    = 1'b0;
          abort_pend_d = 1'b0;
          state_d      = (target_steps == '0) ? ST_DONE : ST_HIGH;
        end
      end

      ST_HIGH: begin
        abort_pend_d = abort_seen;
        // An abort never shortens a high phase. The step always completes
        // and is counted on the falling edge.
        if (phase_expired) begin
          steps_d = steps_inc;
          phase_d = hp_q - HP_ONE;
          if ((steps_inc == target_q) || abort_seen) begin
            state_d = ST_TAIL;
          end else begin
            state_d = ST_LOW;
          end
        end else begin
          phase_d = phase_q - HP_ONE;
        end
      end

      ST_LOW: begin
        abort_pend_d = abort_seen;
        // The low phase always runs to full length, so no pulse is ever
        // shorter than hp_eff low.
        if (phase_expired) begin
          phase_d = hp_q - HP_ONE;
          state_d = abort_seen ? ST_TAIL : ST_HIGH;
        end else begin
          phase_d = phase_q - HP_ONE;
        end
      end

      ST_TAIL: begin
        abort_pend_d = abort_seen;
        if (phase_expired) begin
          // aborted is set as DONE is entered, so it rises together with done.
          aborted_d = abort_seen;
          state_d   = ST_DONE;
        end else begin
          phase_d = phase_q - HP_ONE;
        end
      end

      ST_DONE: begin
        state_d = ST_IDLE;
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    // Output flops load the decode of the next state. Each output therefore
    // changes on the same edge as the state transition that causes it.
    rot_clk_d = (state_d == ST_HIGH);
    rot_en_d  = (state_d == ST_HIGH) || (state_d == ST_LOW) ||
                (state_d == ST_TAIL);
    busy_d    = rot_en_d;
    done_d    = (state_d == ST_DONE);
  end

  // ---------------------------------------------------------------------------
  // State register with synchronous reset
  // ---------------------------------------------------------------------------
  always_ff @(posedge fpga_clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so every
    // register samples its pre-edge value regardless of evaluation order.
    if (sys_init_ctrl) begin
      state_q      <= ST_IDLE;
      phase_q      <= '0;
      hp_q         <= '0;
      target_q     <= '0;
      steps_q      <= '0;
      abort_pend_q <= 1'b0;
      aborted_q    <= 1'b0;
      rot_clk_q    <= 1'b0;
      rot_en_q     <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      phase_q      <= phase_d;
      hp_q         <= hp_d;
      target_q     <= target_d;
      steps_q      <= steps_d;
      abort_pend_q <= abort_pend_d;
      aborted_q    <= aborted_d;
      rot_clk_q    <= rot_clk_d;
      rot_en_q     <= rot_en_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign rot_clk    = rot_clk_q;
  assign rot_en     = rot_en_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign aborted    = aborted_q;
  assign steps_done = steps_q;

endmodule
